// File: rtl/ahb_slave_mem_arb_if.sv
// Bus bundle between two memory requesters, the arbiter and a single-ported memory stub.
// The slave modport is the arbiter; the master modport is the environment (requesters plus memory).
interface ahb_slave_mem_arb_if #(
   parameter int ADDR_BITS = 24
);
   logic                 m0_req;
   logic                 m0_wr;
   logic [ADDR_BITS-1:0] m0_addr;
   logic [31:0]          m0_wdata;
   logic [3:0]           m0_bsel;
   logic                 m0_lock;
   logic                 m0_gnt;
   logic                 m0_rvalid;
   logic [31:0]          m0_rdata;

   logic                 m1_req;
   logic                 m1_wr;
   logic [ADDR_BITS-1:0] m1_addr;
   logic [31:0]          m1_wdata;
   logic [3:0]           m1_bsel;
   logic                 m1_lock;
   logic                 m1_gnt;
   logic                 m1_rvalid;
   logic [31:0]          m1_rdata;

   logic                 WR;
   logic                 RD;
   logic [ADDR_BITS-1:0] ADDR_WR;
   logic [ADDR_BITS-1:0] ADDR_RD;
   logic [31:0]          DIN;
   logic [3:0]           BSEL;
   logic [31:0]          DOUT;

   modport slave (
      input  m0_req, m0_wr, m0_addr, m0_wdata, m0_bsel, m0_lock,
      output m0_gnt, m0_rvalid, m0_rdata,
      input  m1_req, m1_wr, m1_addr, m1_wdata, m1_bsel, m1_lock,
      output m1_gnt, m1_rvalid, m1_rdata,
      output WR, RD, ADDR_WR, ADDR_RD, DIN, BSEL,
      input  DOUT
   );

   modport master (
      output m0_req, m0_wr, m0_addr, m0_wdata, m0_bsel, m0_lock,
      input  m0_gnt, m0_rvalid, m0_rdata,
      output m1_req, m1_wr, m1_addr, m1_wdata, m1_bsel, m1_lock,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  WR, RD, ADDR_WR, ADDR_RD, DIN, BSEL,
      output DOUT
   );
endinterface

// File: rtl/ahb_slave_mem_arb.sv
// Round-robin two-port arbiter onto a single-ported memory stub, with bounded lock bursts,
// registered memory commands and read-data steering to the issuing requester.
module ahb_slave_mem_arb #(
   parameter int ADDR_BITS = 24,
   parameter int MAX_LOCK  = 16
) (
   input logic                clk,
   input logic                reset,
   ahb_slave_mem_arb_if.slave bus
);
   localparam logic [7:0] LP_MAX = 8'(MAX_LOCK);

   logic                 r_last;
   logic                 r_locked;
   logic                 r_lock_own;
   logic [7:0]           r_lock_cnt;

   logic                 r_wr_p1;
   logic                 r_rd_p1;
   logic                 r_rd_own_p1;
   logic [ADDR_BITS-1:0] r_addr_wr_p1;
   logic [ADDR_BITS-1:0] r_addr_rd_p1;
   logic [31:0]          r_din_p1;
   logic [3:0]           r_bsel_p1;
   logic [1:0]           r_rvalid_p2;

   logic                 w_own_req;
   logic                 w_oth_req;
   logic                 w_acc;
   logic                 w_sel;
   logic                 w_restart;
   logic                 w_wr;
   logic                 w_lock;
   logic [ADDR_BITS-1:0] w_addr;
   logic [31:0]          w_wdata;
   logic [3:0]           w_bsel;

   function automatic logic [7:0] f_sat_inc(input logic [7:0] c);
      return (c >= LP_MAX) ? LP_MAX : c + 8'd1;
   endfunction

   always_comb begin
      w_own_req = r_lock_own ? bus.m1_req : bus.m0_req;
      w_oth_req = r_lock_own ? bus.m0_req : bus.m1_req;
      w_acc     = 1'b0;
      w_sel     = 1'b0;
      w_restart = 1'b0;
      if (reset) begin
         if (r_locked && w_own_req) begin
            w_acc = 1'b1;
            if (r_lock_cnt < LP_MAX) begin
               w_sel = r_lock_own;
            end else if (w_oth_req) begin
               w_sel = ~r_lock_own;
            end else begin
               // Budget spent but nobody else waiting: owner keeps going on a fresh count.
               w_sel     = r_lock_own;
               w_restart = 1'b1;
            end
         end else if (bus.m0_req && bus.m1_req) begin
            w_acc = 1'b1;
            w_sel = ~r_last;
         end else if (bus.m0_req) begin
            w_acc = 1'b1;
            w_sel = 1'b0;
         end else if (bus.m1_req) begin
            w_acc = 1'b1;
            w_sel = 1'b1;
         end
      end
   end

   always_comb begin
      w_wr    = w_sel ? bus.m1_wr    : bus.m0_wr;
      w_lock  = w_sel ? bus.m1_lock  : bus.m0_lock;
      w_addr  = w_sel ? bus.m1_addr  : bus.m0_addr;
      w_wdata = w_sel ? bus.m1_wdata : bus.m0_wdata;
      w_bsel  = w_sel ? bus.m1_bsel  : bus.m0_bsel;
   end

   assign bus.m0_gnt = w_acc & ~w_sel;
   assign bus.m1_gnt = w_acc &  w_sel;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_last     <= 1'b1;
         r_locked   <= 1'b0;
         r_lock_own <= 1'b0;
         r_lock_cnt <= 8'd0;
      end else if (w_acc) begin
         r_last <= w_sel;
         if (w_lock) begin
            r_locked   <= 1'b1;
            r_lock_own <= w_sel;
            r_lock_cnt <= (r_locked && (r_lock_own == w_sel) && !w_restart) ?
                          f_sat_inc(r_lock_cnt) : 8'd1;
         end else begin
            r_locked   <= 1'b0;
            r_lock_cnt <= 8'd0;
         end
      end else if (r_locked && !w_own_req) begin
         r_locked   <= 1'b0;
         r_lock_cnt <= 8'd0;
      end
   end

   // Stage p1: registered memory command; stage p2: read-data qualifier
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_p1      <= 1'b0;
         r_rd_p1      <= 1'b0;
         r_rd_own_p1  <= 1'b0;
         r_addr_wr_p1 <= '0;
         r_addr_rd_p1 <= '0;
         r_din_p1     <= '0;
         r_bsel_p1    <= '0;
         r_rvalid_p2  <= 2'b00;
      end else begin
         r_wr_p1 <= w_acc &  w_wr;
         r_rd_p1 <= w_acc & ~w_wr;
         if (w_acc && w_wr) begin
            r_addr_wr_p1 <= w_addr;
            r_din_p1     <= w_wdata;
            r_bsel_p1    <= w_bsel;
         end
         if (w_acc && !w_wr) begin
            r_addr_rd_p1 <= w_addr;
            r_rd_own_p1  <= w_sel;
         end
         r_rvalid_p2 <= {r_rd_p1 & r_rd_own_p1, r_rd_p1 & ~r_rd_own_p1};
      end
   end

   assign bus.WR      = r_wr_p1;
   assign bus.RD      = r_rd_p1;
   assign bus.ADDR_WR = r_addr_wr_p1;
   assign bus.ADDR_RD = r_addr_rd_p1;
   assign bus.DIN     = r_din_p1;
   assign bus.BSEL    = r_bsel_p1;

   assign bus.m0_rvalid = r_rvalid_p2[0];
   assign bus.m1_rvalid = r_rvalid_p2[1];
   assign bus.m0_rdata  = bus.DOUT;
   assign bus.m1_rdata  = bus.DOUT;
endmodule

// File: doc/ahb_slave_mem_arb.md
# ahb_slave_mem_arb

Two-port arbiter that shares the single-ported memory stub interface (WR/RD, ADDR_WR/ADDR_RD, DIN, BSEL, DOUT) between two requesters, e.g. the AHB slave datapath and a test/backdoor port. It grants one access per cycle by round-robin, supports bounded locked bursts, drives registered memory commands, and steers returned read data to the requester that issued the read.

## Interface
- ADDR_BITS, 24, width of memory word address.
- MAX_LOCK, 16, max consecutive locked grants to one requester before forced rotation; legal range 1..255.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- m0_req / m1_req  in  1  access request; held until accepted (req & gnt).
- m0_wr / m1_wr  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  ADDR_BITS  word address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_bsel / m1_bsel  in  4  write byte enables.
- m0_lock / m1_lock  in  1  request to keep the grant for the next access.
- m0_gnt / m1_gnt  out  1  combinational grant; accepted when req & gnt.
- m0_rvalid / m1_rvalid  out  1  read data valid for that requester.
- m0_rdata / m1_rdata  out  32  read data (DOUT passthrough; qualify with rvalid).
- WR  out  1  registered memory write strobe.
- RD  out  1  registered memory read strobe.
- ADDR_WR / ADDR_RD  out  ADDR_BITS  registered write/read address.
- DIN  out  32  registered write data.
- BSEL  out  4  registered byte enables.
- DOUT  in  32  memory read data, valid the cycle after RD.

## Operation
- State: last (owner of most recent accepted access), locked, lock_own, lock_cnt (8 bits).
- At most one gnt high per cycle; gnt only if that requester's req is high.
- Lock hold: if locked and lock_own req high and lock_cnt < MAX_LOCK, grant lock_own regardless of other req.
- Otherwise round-robin: both req -> grant requester != last; one req -> grant it; none -> no grant.
- Forced rotation: lock_cnt == MAX_LOCK and other requester req high -> grant other; lock_cnt := 0, locked := 0. If other idle, lock_own continues and lock_cnt restarts at 1.
- On acceptance by X: last := X. If mX_lock: locked := 1, lock_own := X, lock_cnt := (lock_own==X && locked) ? lock_cnt+1 : 1. If !mX_lock: locked := 0, lock_cnt := 0.
- Lock owner deasserting req clears locked and lock_cnt in that cycle.
- Accepted write: next cycle WR=1, ADDR_WR=addr, DIN=wdata, BSEL=bsel; RD=0.
- Accepted read: next cycle RD=1, ADDR_RD=addr; WR=0; BSEL/DIN hold previous values.
- No acceptance: WR=RD=0 next cycle; address/data registers hold.
- Read tag (valid + owner) pipelined with RD; in the cycle after RD, mX_rvalid=1 for tagged owner only; both mX_rdata = DOUT.
- Back-to-back accepts, any read/write mix, full throughput one per cycle.

## Timing
- Accept in cycle T -> memory strobe in T+1 -> (reads) rvalid in T+2. Read latency 2 cycles from acceptance.
- gnt is combinational from req and registered state; no req->gnt loop through memory side.
- Reset (reset==0 at rising edge): WR=RD=0, ADDR_WR=ADDR_RD=0, DIN=0, BSEL=0, rvalid=0 both, read tags cleared, last=1 (so m0 wins first tie), locked=0, lock_cnt=0. m0_gnt=m1_gnt=0 while reset low.
- Reset mid-operation: accesses accepted before reset produce no strobe or rvalid after reset; in-flight reads dropped.
- Simultaneous req with lock on both: lock rules apply to current lock_own only; other's lock takes effect when it is next granted.
- lock_cnt saturates at MAX_LOCK; never wraps.

## Test plan
- Single write: m0 write addr 0x10, data 0xDEADBEEF, bsel 0xF in T -> T+1 WR=1, ADDR_WR=0x10, DIN=0xDEADBEEF, BSEL=0xF; no rvalid.
- Single read: m1 read addr 0x20 in T, DOUT=0x12345678 in T+2 -> m1_rvalid=1 at T+2, m1_rdata=0x12345678, m0_rvalid=0.
- Round-robin: both req continuously after reset -> grants m0,m1,m0,m1...; memory strobe every cycle; rvalid owners match grant order delayed 2.
- Lock burst: MAX_LOCK=4, m0 req+lock continuous, m1 req continuous -> m0 granted 4 cycles, then m1 once, then m0 again.
- Lock release: m0 locks 2 accesses then lock=0 on third -> m1 (requesting) granted on fourth cycle.
- Reset mid-read: m0 read accepted T, reset low at T+1 -> RD=0 after reset, no m0_rvalid at T+2; all outputs at reset values.
